multi_hart_dbg_ctrl: RTL

MULTI_HART_DBG_CTRL -- requirements
Module: multi_hart_dbg_ctrl

---
 rtl/multi_hart_dbg_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_hart_dbg_ctrl.sv
// Multi-hart debug controller: per-hart run-control FSMs (halt/resume with
// sticky resume acknowledge), status summaries over the selected hart set,
// and an abstract-register access engine with timeout and sticky cmderr.
module multi_hart_dbg_ctrl #(
  parameter int NUM_HARTS  = 4,
  parameter int AR_TIMEOUT = 64,
  parameter int HSW        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      dm_haltreq_i,
  input  logic                      dm_resumereq_i,
  input  logic [HSW-1:0]            dm_hartsel_i,
  input  logic [NUM_HARTS-1:0]      dm_hamask_i,
  input  logic                      dm_ar_en_i,
  input  logic                      dm_ar_wr_i,
  input  logic [15:0]               dm_ar_ad_i,
  input  logic [31:0]               dm_ar_wdata_i,
  output logic [31:0]               dm_ar_rdata_o,
  output logic                      dm_ar_done_o,
  output logic                      dm_ar_busy_o,
  output logic [2:0]                dm_ar_err_o,
  input  logic                      dm_ar_errclr_i,
  output logic                      dm_allhalted_o,
  output logic                      dm_anyhalted_o,
  output logic                      dm_allrunning_o,
  output logic                      dm_anyrunning_o,
  output logic                      dm_allresumeack_o,
  output logic                      dm_anyresumeack_o,
  output logic [NUM_HARTS-1:0]      hart_haltreq_o,
  output logic [NUM_HARTS-1:0]      hart_resumereq_o,
  input  logic [NUM_HARTS-1:0]      hart_halted_i,
  input  logic [NUM_HARTS-1:0]      hart_resumeack_i,
  output logic [NUM_HARTS-1:0]      hart_ar_en_o,
  output logic                      hart_ar_wr_o,
  output logic [15:0]               hart_ar_ad_o,
  output logic [31:0]               hart_ar_wdata_o,
  input  logic [NUM_HARTS*32-1:0]   hart_ar_rdata_i,
  input  logic [NUM_HARTS-1:0]      hart_ar_done_i
);

  localparam int CW = $clog2(AR_TIMEOUT + 1);

  typedef enum logic [1:0] {H_RUN = 2'd0, H_HALTING = 2'd1, H_HALTED = 2'd2, H_RESUMING = 2'd3} hst_e;
  typedef enum logic [1:0] {A_IDLE = 2'd0, A_ACCESS = 2'd1, A_WAIT = 2'd2, A_DONE = 2'd3} ast_e;

  hst_e                 hst_q [NUM_HARTS];
  hst_e                 hst_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] rack_q, rack_d;
  ast_e                 ar_q, ar_d;
  logic [2:0]           err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [HSW-1:0]       sel_q, sel_d;
  logic                 wr_q, wr_d;
  logic [15:0]          ad_q, ad_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 hsel_valid_s;
  logic [NUM_HARTS-1:0] hsel_oh_s, sel_mask_s, halted_vec_s, run_vec_s;
  logic [NUM_HARTS-1:0] sel_oh_s;
  logic                 tgt_halted_s, done_sel_s;
  logic [31:0]          rdata_sel_s;
  logic                 err_set_s;
  logic [2:0]           err_val_s;

  // Decode the selected hart set and per-hart status vectors.
  always_comb begin
    hsel_valid_s = (32'(dm_hartsel_i) < 32'(NUM_HARTS));
    for (int i = 0; i < NUM_HARTS; i++) begin
      hsel_oh_s[i]    = hsel_valid_s && (dm_hartsel_i == HSW'(i));
      sel_mask_s[i]   = dm_hamask_i[i] | hsel_oh_s[i];
      halted_vec_s[i] = (hst_q[i] == H_HALTED);
      run_vec_s[i]    = (hst_q[i] == H_RUN);
    end
    tgt_halted_s = |(hsel_oh_s & halted_vec_s);
  end

  // Hart FSM state and sticky resume-ack registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_HARTS; i++) hst_q[i] <= H_RUN;
      rack_q <= {NUM_HARTS{1'b0}};
    end else begin
      hst_q  <= hst_d;
      rack_q <= rack_d;
    end
  end

  // Hart FSM next state; a halt request beats a simultaneous resume request.
  always_comb begin
    rack_d = rack_q;
    for (int i = 0; i < NUM_HARTS; i++) begin
      hst_d[i] = hst_q[i];
      case (hst_q[i])
        H_RUN: begin
          if (hart_halted_i[i]) hst_d[i] = H_HALTED;
          else if (sel_mask_s[i] && dm_haltreq_i) hst_d[i] = H_HALTING;
          else hst_d[i] = H_RUN;
        end
        H_HALTING: begin
          if (hart_halted_i[i]) hst_d[i] = H_HALTED;
          else hst_d[i] = H_HALTING;
        end
        H_HALTED: begin
          if (sel_mask_s[i] && dm_resumereq_i && !dm_haltreq_i) begin
            hst_d[i]  = H_RESUMING;
            rack_d[i] = 1'b0;
          end else begin
            hst_d[i] = H_HALTED;
          end
        end
        H_RESUMING: begin
          if (hart_resumeack_i[i]) begin
            hst_d[i]  = H_RUN;
            rack_d[i] = 1'b1;
          end else begin
            hst_d[i] = H_RESUMING;
          end
        end
        default: hst_d[i] = H_RUN;
      endcase
    end
  end

  // Hart request outputs and status summaries over the selected set.
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      hart_haltreq_o[i]   = (hst_q[i] == H_HALTING);
      hart_resumereq_o[i] = (hst_q[i] == H_RESUMING);
    end
    dm_anyhalted_o    = |(sel_mask_s & halted_vec_s);
    dm_allhalted_o    = (|sel_mask_s) && ((sel_mask_s & halted_vec_s) == sel_mask_s);
    dm_anyrunning_o   = |(sel_mask_s & run_vec_s);
    dm_allrunning_o   = (|sel_mask_s) && ((sel_mask_s & run_vec_s) == sel_mask_s);
    dm_anyresumeack_o = |(sel_mask_s & rack_q);
    dm_allresumeack_o = (|sel_mask_s) && ((sel_mask_s & rack_q) == sel_mask_s);
  end

  // Decode the latched target hart and mux its completion and read data.
  always_comb begin
    rdata_sel_s = 32'd0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      sel_oh_s[i] = (sel_q == HSW'(i));
      if (sel_oh_s[i]) rdata_sel_s = hart_ar_rdata_i[i*32 +: 32];
      else rdata_sel_s = rdata_sel_s;
    end
    done_sel_s = |(hart_ar_done_i & sel_oh_s);
  end

  // Abstract-register engine state and command registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ar_q    <= A_IDLE;
      err_q   <= 3'd0;
      cnt_q   <= {CW{1'b0}};
      sel_q   <= {HSW{1'b0}};
      wr_q    <= 1'b0;
      ad_q    <= 16'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      ar_q    <= ar_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      ad_q    <= ad_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Abstract-register next state; a new error outranks an error clear.
  always_comb begin
    ar_d      = ar_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    ad_d      = ad_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_set_s = 1'b0;
    err_val_s = 3'd0;
    case (ar_q)
      A_IDLE: begin
        if (!dm_ar_en_i) begin
          ar_d = A_IDLE;
        end else if (err_q != 3'd0) begin
          ar_d = A_DONE;
        end else if (!tgt_halted_s) begin
          ar_d      = A_DONE;
          err_set_s = 1'b1;
          err_val_s = 3'd4;
        end else begin
          ar_d    = A_ACCESS;
          sel_d   = dm_hartsel_i;
          wr_d    = dm_ar_wr_i;
          ad_d    = dm_ar_ad_i;
          wdata_d = dm_ar_wdata_i;
        end
      end
      A_ACCESS: begin
        ar_d  = A_WAIT;
        cnt_d = {CW{1'b0}};
        if (dm_ar_en_i) begin
          err_set_s = 1'b1;
          err_val_s = 3'd1;
        end else begin
          err_set_s = 1'b0;
        end
      end
      A_WAIT: begin
        if (done_sel_s) begin
          ar_d = A_DONE;
          if (!wr_q) rdata_d = rdata_sel_s;
          else rdata_d = rdata_q;
          if (dm_ar_en_i) begin
            err_set_s = 1'b1;
            err_val_s = 3'd1;
          end else begin
            err_set_s = 1'b0;
          end
        end else if (cnt_q == CW'(AR_TIMEOUT - 1)) begin
          ar_d      = A_DONE;
          err_set_s = 1'b1;
          err_val_s = 3'd3;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (dm_ar_en_i) begin
            err_set_s = 1'b1;
            err_val_s = 3'd1;
          end else begin
            err_set_s = 1'b0;
          end
        end
      end
      A_DONE: ar_d = A_IDLE;
      default: ar_d = A_IDLE;
    endcase
    if (err_set_s) err_d = err_val_s;
    else if (dm_ar_errclr_i) err_d = 3'd0;
    else err_d = err_q;
  end

  // Abstract-register outputs, decoded from registered state only.
  always_comb begin
    if (ar_q == A_ACCESS) hart_ar_en_o = sel_oh_s;
    else hart_ar_en_o = {NUM_HARTS{1'b0}};
    dm_ar_busy_o    = (ar_q == A_ACCESS) || (ar_q == A_WAIT);
    dm_ar_done_o    = (ar_q == A_DONE);
    dm_ar_err_o     = err_q;
    dm_ar_rdata_o   = rdata_q;
    hart_ar_wr_o    = wr_q;
    hart_ar_ad_o    = ad_q;
    hart_ar_wdata_o = wdata_q;
  end

endmodule
